// File: rtl/ahblite_uart_tx_if.sv
// AHB-Lite slave port bundle for the UART transmitter on interconnect port P3.
// The master drives the address/data phases and the slave returns ready, response and read data.
interface ahblite_uart_tx_if;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE;
    logic [3:0]  HPROT;
    logic        HWRITE;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic        HREADYOUT;
    logic        HRESP;
    logic [31:0] HRDATA;

    modport master (
        output HSEL,
        output HADDR,
        output HTRANS,
        output HSIZE,
        output HPROT,
        output HWRITE,
        output HWDATA,
        output HREADY,
        input  HREADYOUT,
        input  HRESP,
        input  HRDATA
    );

    modport slave (
        input  HSEL,
        input  HADDR,
        input  HTRANS,
        input  HSIZE,
        input  HPROT,
        input  HWRITE,
        input  HWDATA,
        input  HREADY,
        output HREADYOUT,
        output HRESP,
        output HRDATA
    );
endinterface

// File: rtl/ahblite_uart_tx.sv
// Zero-wait-state AHB-Lite UART transmitter: CPU writes fill a TX FIFO that is drained
// as 8N1 frames on TXD, with a level TX-empty interrupt.
module ahblite_uart_tx #(
    parameter int          FIFO_DEPTH  = 16,
    parameter logic [15:0] BAUDDIV_RST = 16'd433
) (
    input  logic               HCLK,
    input  logic               HRESET,
    ahblite_uart_tx_if.slave   bus,
    output logic               TXD,
    output logic               IRQ_TX
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t        state;
    state_t        state_next;

    logic          dp_valid;
    logic          dp_write;
    logic [1:0]    dp_addr;

    logic [15:0]   bauddiv;
    logic [15:0]   baud_cnt;
    logic          ie;
    logic          ovf;

    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [7:0]    fifo_rdata;

    logic [7:0]    shift;
    logic [7:0]    shift_next;
    logic [2:0]    bit_idx;
    logic [2:0]    bit_idx_next;
    logic          txd_next;

    logic          wr_en;
    logic          push;
    logic          push_ok;
    logic          pop;
    logic          ovf_set;
    logic          ovf_clr;
    logic          empty;
    logic          full;
    logic          busy;
    logic          bit_tick;
    logic          unused_bits;

    assign bus.HREADYOUT = 1'b1;
    assign bus.HRESP     = 1'b0;

    assign unused_bits = ^{bus.HSIZE, bus.HPROT, bus.HADDR[31:4], bus.HADDR[1:0], bus.HWDATA[31:16]};

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            dp_valid <= 1'b0;
            dp_write <= 1'b0;
            dp_addr  <= 2'd0;
        end else if (bus.HREADY) begin
            dp_valid <= bus.HSEL & bus.HTRANS[1];
            dp_write <= bus.HWRITE;
            dp_addr  <= bus.HADDR[3:2];
        end
    end

    assign wr_en   = dp_valid & dp_write & bus.HREADY;
    assign push    = wr_en && (dp_addr == 2'd0);
    assign ovf_clr = wr_en && (dp_addr == 2'd1) && bus.HWDATA[3];

    assign empty      = (count == '0);
    assign full       = (count == FULL_COUNT);
    assign busy       = (state != IDLE);
    assign fifo_rdata = fifo_mem[rd_ptr];

    // A full FIFO still accepts a byte when the transmitter frees a slot on the same edge.
    assign push_ok = push && (!full || pop);
    assign ovf_set = push && full && !pop;

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            bauddiv <= BAUDDIV_RST;
            ie      <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            if (wr_en && (dp_addr == 2'd2)) begin
                bauddiv <= bus.HWDATA[15:0];
            end
            if (wr_en && (dp_addr == 2'd3)) begin
                ie <= bus.HWDATA[0];
            end
            if (ovf_set) begin
                ovf <= 1'b1;
            end else if (ovf_clr) begin
                ovf <= 1'b0;
            end
        end
    end

    always_ff @(posedge HCLK) begin
        if (push_ok) begin
            fifo_mem[wr_ptr] <= bus.HWDATA[7:0];
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_ok, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    assign bit_tick = busy && (baud_cnt == bauddiv);

    always_ff @(posedge HCLK) begin
        if (HRESET || (state == IDLE) || bit_tick) begin
            baud_cnt <= '0;
        end else begin
            baud_cnt <= baud_cnt + 16'd1;
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state   <= IDLE;
            shift   <= '0;
            bit_idx <= '0;
            TXD     <= 1'b1;
        end else begin
            state   <= state_next;
            shift   <= shift_next;
            bit_idx <= bit_idx_next;
            TXD     <= txd_next;
        end
    end

    // TXD is registered from the current state, so the line trails the FSM by one cycle.
    always_comb begin
        state_next   = state;
        shift_next   = shift;
        bit_idx_next = bit_idx;
        pop          = 1'b0;
        txd_next     = 1'b1;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop        = 1'b1;
                    shift_next = fifo_rdata;
                    state_next = START;
                end
            end
            START: begin
                txd_next = 1'b0;
                if (bit_tick) begin
                    bit_idx_next = 3'd0;
                    state_next   = DATA;
                end
            end
            DATA: begin
                txd_next = shift[0];
                if (bit_tick) begin
                    shift_next   = {1'b0, shift[7:1]};
                    bit_idx_next = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
                        state_next = STOP;
                    end
                end
            end
            STOP: begin
                txd_next = 1'b1;
                if (bit_tick) begin
                    if (!empty) begin
                        pop        = 1'b1;
                        shift_next = fifo_rdata;
                        state_next = START;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_comb begin
        bus.HRDATA = '0;
        if (dp_valid && !dp_write) begin
            case (dp_addr)
                2'd1:    bus.HRDATA = {28'h0, ovf, busy, empty, full};
                2'd2:    bus.HRDATA = {16'h0, bauddiv};
                2'd3:    bus.HRDATA = {31'h0, ie};
                default: bus.HRDATA = '0;
            endcase
        end
    end

    assign IRQ_TX = ie & empty & ~busy;
endmodule

// File: tb/tb_ahblite_uart_tx.sv
// Self-checking bench for ahblite_uart_tx: register vectors, directed UART timing sequences,
// and randomized traffic checked by a frame-level receiver model and byte scoreboard.
module tb_ahblite_uart_tx;
    logic HCLK = 1'b0;
    logic HRESET;
    logic TXD;
    logic IRQ_TX;

    ahblite_uart_tx_if bus();

    ahblite_uart_tx #(
        .FIFO_DEPTH (16),
        .BAUDDIV_RST(16'd433)
    ) dut (
        .HCLK  (HCLK),
        .HRESET(HRESET),
        .bus   (bus),
        .TXD   (TXD),
        .IRQ_TX(IRQ_TX)
    );

    always #5 HCLK = ~HCLK;

    int errors = 0;
    int checks = 0;

    // Receiver model: expected bytes in order, bit length in cycles, and frame start times.
    byte         exp_q[$];
    int unsigned fstart[$];
    bit          mon_en = 1'b0;
    int          mon_l  = 1;
    bit          in_frame = 1'b0;
    int          fpos = 0;
    int unsigned cyc = 0;
    logic        fbuf [0:2047];

    typedef struct {
        bit          write;
        bit [1:0]    addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        bit          chk;
    } vec_t;

    vec_t vecs [12];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input bit sel, input bit write, input bit [1:0] addr,
                                 input logic [31:0] wdata, output logic [31:0] rdata);
        logic [31:0] base;
        base = $urandom();
        bus.HSEL   = sel;
        bus.HTRANS = 2'b10;
        bus.HADDR  = {base[31:4], addr, base[1:0]};
        bus.HWRITE = write;
        bus.HSIZE  = 3'($urandom_range(0, 2));
        bus.HPROT  = 4'($urandom_range(0, 15));
        @(posedge HCLK);
        #1;
        rdata      = bus.HRDATA;
        bus.HSEL   = 1'b0;
        bus.HTRANS = 2'b00;
        bus.HWRITE = 1'b0;
        bus.HWDATA = wdata;
        checkOutput("hreadyout", {31'h0, bus.HREADYOUT}, 32'h1);
        checkOutput("hresp", {31'h0, bus.HRESP}, 32'h0);
        @(posedge HCLK);
        #1;
    endtask

    task automatic wr(input bit [1:0] addr, input logic [31:0] data);
        logic [31:0] dummy;
        applyStimulus(1'b1, 1'b1, addr, data, dummy);
    endtask

    task automatic rd(input bit [1:0] addr, input logic [31:0] expected, input string name);
        logic [31:0] got;
        applyStimulus(1'b1, 1'b0, addr, $urandom(), got);
        checkOutput(name, got, expected);
    endtask

    task automatic waitDrain(input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || in_frame) && n < budget) begin
            @(negedge HCLK);
            n++;
        end
        checkOutput("drain_pending", exp_q.size(), 32'h0);
    endtask

    // Frame receiver: a frame is 10 bits of mon_l cycles each: low start, LSB-first data, high stop.
    always @(negedge HCLK) begin
        byte b;
        byte rx;
        int  bad;
        int  k;
        logic e;
        cyc++;
        if (!mon_en) begin
            in_frame = 1'b0;
        end else begin
            if (!in_frame && TXD === 1'b0) begin
                in_frame = 1'b1;
                fpos     = 0;
                fstart.push_back(cyc);
            end
            if (in_frame) begin
                if (fpos < 2048) fbuf[fpos] = TXD;
                fpos++;
                if (fpos == 10 * mon_l) begin
                    in_frame = 1'b0;
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("[TB] FAIL frame: got an unexpected frame, expected none");
                    end else begin
                        b   = exp_q.pop_front();
                        bad = 0;
                        for (int i = 0; i < 10 * mon_l; i++) begin
                            k = i / mon_l;
                            e = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : b[k-1];
                            if (fbuf[i] !== e) bad++;
                        end
                        for (int j = 0; j < 8; j++) rx[j] = fbuf[(j + 1) * mon_l + mon_l / 2];
                        if (bad != 0) begin
                            errors++;
                            $display("[TB] FAIL frame: got byte 0x%0h with %0d wrong samples, expected byte 0x%0h", rx, bad, b);
                        end
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        int lows;
        int div;
        byte data_b;

        vecs[0]  = '{1'b0, 2'd1, 32'h0,          32'h2,          1'b1};
        vecs[1]  = '{1'b0, 2'd2, 32'h0,          32'h0000_01B1,  1'b1};
        vecs[2]  = '{1'b0, 2'd3, 32'h0,          32'h0,          1'b1};
        vecs[3]  = '{1'b0, 2'd0, 32'h0,          32'h0,          1'b1};
        vecs[4]  = '{1'b1, 2'd2, 32'h0001_0010,  32'h0,          1'b0};
        vecs[5]  = '{1'b0, 2'd2, 32'h0,          32'h0000_0010,  1'b1};
        vecs[6]  = '{1'b1, 2'd3, 32'h3,          32'h0,          1'b0};
        vecs[7]  = '{1'b0, 2'd3, 32'h0,          32'h1,          1'b1};
        vecs[8]  = '{1'b1, 2'd3, 32'h0,          32'h0,          1'b0};
        vecs[9]  = '{1'b0, 2'd3, 32'h0,          32'h0,          1'b1};
        vecs[10] = '{1'b1, 2'd1, 32'hF,          32'h0,          1'b0};
        vecs[11] = '{1'b0, 2'd1, 32'h0,          32'h2,          1'b1};

        bus.HSEL = 1'b0; bus.HADDR = '0; bus.HTRANS = 2'b00; bus.HSIZE = 3'd2;
        bus.HPROT = 4'd0; bus.HWRITE = 1'b0; bus.HWDATA = '0; bus.HREADY = 1'b1;
        HRESET = 1'b1;
        repeat (3) @(posedge HCLK);
        #1;
        HRESET = 1'b0;

        @(negedge HCLK);
        checkOutput("reset_txd", {31'h0, TXD}, 32'h1);
        checkOutput("reset_irq", {31'h0, IRQ_TX}, 32'h0);
        checkOutput("reset_hrdata", bus.HRDATA, 32'h0);

        $display("[TB] register vectors");
        for (int i = 0; i < 12; i++) begin
            if (vecs[i].write) begin
                wr(vecs[i].addr, vecs[i].wdata);
            end else if (vecs[i].chk) begin
                rd(vecs[i].addr, vecs[i].exp_rdata, $sformatf("vec%0d", i));
            end
        end

        $display("[TB] T1 single frame 0x55 at BAUDDIV=3");
        wr(2'd2, 32'd3);
        mon_l  = 4;
        mon_en = 1'b1;
        exp_q.push_back(8'h55);
        wr(2'd0, 32'h55);
        @(negedge HCLK);
        @(negedge HCLK);
        checkOutput("t1_txd_at_plus1", {31'h0, TXD}, 32'h1);
        @(negedge HCLK);
        checkOutput("t1_txd_at_plus2", {31'h0, TXD}, 32'h0);
        waitDrain(200);
        rd(2'd1, 32'h2, "t1_status");

        $display("[TB] T2 back-to-back frames at BAUDDIV=0");
        wr(2'd2, 32'd0);
        mon_l = 1;
        fstart.delete();
        exp_q.push_back(8'hA5);
        wr(2'd0, 32'hA5);
        exp_q.push_back(8'h3C);
        wr(2'd0, 32'h3C);
        waitDrain(100);
        checkOutput("t2_frames", fstart.size(), 32'd2);
        if (fstart.size() >= 2) checkOutput("t2_gap", fstart[1] - fstart[0], 32'd10);
        rd(2'd1, 32'h2, "t2_status");

        $display("[TB] T4 interrupt");
        wr(2'd2, 32'd3);
        mon_l = 4;
        wr(2'd3, 32'h1);
        @(negedge HCLK);
        checkOutput("t4_irq_idle", {31'h0, IRQ_TX}, 32'h1);
        exp_q.push_back(8'h81);
        wr(2'd0, 32'h81);
        // Pop at +1, then 10 bits of 4 cycles each before the FSM is back in IDLE.
        for (n = 0; n < 200; n++) begin
            @(negedge HCLK);
            if (IRQ_TX) break;
        end
        checkOutput("t4_irq_low_cycles", n, 32'd41);
        waitDrain(100);
        checkOutput("t4_irq_after_stop", {31'h0, IRQ_TX}, 32'h1);
        wr(2'd3, 32'h0);
        @(negedge HCLK);
        checkOutput("t4_irq_disabled", {31'h0, IRQ_TX}, 32'h0);

        $display("[TB] T3 FIFO overflow");
        wr(2'd2, 32'd100);
        mon_l = 101;
        for (int i = 0; i < 18; i++) begin
            data_b = byte'($urandom_range(0, 255));
            if (i < 17) exp_q.push_back(data_b);
            wr(2'd0, {24'h0, data_b});
        end
        rd(2'd1, 32'hD, "t3_status_ovf");
        wr(2'd1, 32'h8);
        rd(2'd1, 32'h5, "t3_status_w1c");
        waitDrain(17600);
        rd(2'd1, 32'h2, "t3_status_end");

        $display("[TB] T5 reset mid-frame");
        mon_en = 1'b0;
        wr(2'd2, 32'd3);
        for (int i = 0; i < 4; i++) wr(2'd0, 32'h00);
        repeat (10) @(posedge HCLK);
        @(negedge HCLK);
        checkOutput("t5_txd_pre_reset", {31'h0, TXD}, 32'h0);
        HRESET = 1'b1;
        @(posedge HCLK);
        #1;
        HRESET = 1'b0;
        @(negedge HCLK);
        checkOutput("t5_txd_after_reset", {31'h0, TXD}, 32'h1);
        checkOutput("t5_irq_after_reset", {31'h0, IRQ_TX}, 32'h0);
        rd(2'd1, 32'h2, "t5_status");
        rd(2'd2, 32'd433, "t5_bauddiv");
        rd(2'd3, 32'h0, "t5_ctrl");
        lows = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge HCLK);
            if (TXD !== 1'b1) lows++;
        end
        checkOutput("t5_no_tx_after_reset", lows, 32'h0);

        $display("[TB] randomized traffic");
        div = $urandom_range(0, 4);
        wr(2'd2, div);
        mon_l  = div + 1;
        mon_en = 1'b1;
        for (int i = 0; i < 12; i++) begin
            logic [31:0] dummy;
            repeat ($urandom_range(0, 30)) @(posedge HCLK);
            #1;
            data_b = byte'($urandom_range(0, 255));
            if ($urandom_range(0, 3) == 0) begin
                applyStimulus(1'b0, 1'b1, 2'd0, {24'h0, data_b}, dummy);
            end else begin
                exp_q.push_back(data_b);
                wr(2'd0, {24'h0, data_b});
            end
        end
        waitDrain(3000);
        rd(2'd1, 32'h2, "rand_status_end");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
